// File: rtl/cache_fill_ctrl_if.sv
// CPU request/response, flush and data-memory signals of the direct-mapped
// cache fill controller, grouped as one bus.
interface cache_fill_ctrl_if;
   logic         cpu_req;
   logic [14:0]  cpu_addr;
   logic         cpu_ready;
   logic         resp_valid;
   logic [31:0]  resp_data;
   logic         resp_hit;
   logic         flush;
   logic [14:0]  mem_addr;
   logic         mem_rd;
   logic [127:0] mem_line;
   logic [15:0]  hit_cnt;
   logic [15:0]  miss_cnt;

   modport slave (
      input  cpu_req, cpu_addr, flush, mem_line,
      output cpu_ready, resp_valid, resp_data, resp_hit, mem_addr, mem_rd,
             hit_cnt, miss_cnt
   );

   modport master (
      output cpu_req, cpu_addr, flush, mem_line,
      input  cpu_ready, resp_valid, resp_data, resp_hit, mem_addr, mem_rd,
             hit_cnt, miss_cnt
   );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Direct-mapped read cache with 4-word lines: hits answer next cycle, misses
// hold a block read for MEM_LATENCY cycles and then fill and answer.
module cache_fill_ctrl #(
   parameter int INDEX_BITS  = 5,
   parameter int MEM_LATENCY = 2
) (
   input logic          clk,
   input logic          rst,
   cache_fill_ctrl_if.slave bus
);
   localparam int NLINES = 1 << INDEX_BITS;
   localparam int TAG_W  = 13 - INDEX_BITS;

   typedef enum logic {IDLE, FILL} state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [14:0]         addr_q, addr_d;
   logic [NLINES-1:0]   valid_q, valid_d;
   logic                resp_valid_q, resp_valid_d;
   logic                resp_hit_q, resp_hit_d;
   logic [31:0]         resp_data_q, resp_data_d;
   logic [14:0]         mem_addr_q, mem_addr_d;
   logic                mem_rd_q, mem_rd_d;
   logic [15:0]         hit_cnt_q, hit_cnt_d;
   logic [15:0]         miss_cnt_q, miss_cnt_d;

   logic [TAG_W-1:0]    tag_mem  [NLINES];
   logic [127:0]        line_mem [NLINES];

   logic [INDEX_BITS-1:0] req_idx, fill_idx;
   logic [TAG_W-1:0]      req_tag, fill_tag;
   logic                  hit, fill_done;

   function automatic logic [31:0] sel_word(input logic [127:0] line, input logic [1:0] off);
      case (off)
         2'd0:    sel_word = line[127:96];
         2'd1:    sel_word = line[95:64];
         2'd2:    sel_word = line[63:32];
         default: sel_word = line[31:0];
      endcase
   endfunction

   assign req_idx   = bus.cpu_addr[INDEX_BITS+1:2];
   assign req_tag   = bus.cpu_addr[14:INDEX_BITS+2];
   assign fill_idx  = addr_q[INDEX_BITS+1:2];
   assign fill_tag  = addr_q[14:INDEX_BITS+2];
   assign hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
   assign fill_done = (state_q == FILL) && (cnt_q == 4'(MEM_LATENCY));

   assign bus.cpu_ready  = (state_q == IDLE) && !bus.flush;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_hit   = resp_hit_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_rd     = mem_rd_q;
   assign bus.hit_cnt    = hit_cnt_q;
   assign bus.miss_cnt   = miss_cnt_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      valid_d      = valid_q;
      resp_valid_d = 1'b0;
      resp_hit_d   = resp_hit_q;
      resp_data_d  = resp_data_q;
      mem_addr_d   = mem_addr_q;
      mem_rd_d     = mem_rd_q;
      hit_cnt_d    = hit_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      if (state_q == IDLE) begin
         // flush wins over a same-cycle request, which stays unaccepted
         if (bus.flush) begin
            valid_d = '0;
         end else if (bus.cpu_req) begin
            if (hit) begin
               resp_valid_d = 1'b1;
               resp_hit_d   = 1'b1;
               resp_data_d  = sel_word(line_mem[req_idx], bus.cpu_addr[1:0]);
               if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
            end else begin
               state_d    = FILL;
               cnt_d      = 4'd1;
               addr_d     = bus.cpu_addr;
               mem_addr_d = {bus.cpu_addr[14:2], 2'b00};
               mem_rd_d   = 1'b1;
               if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
            end
         end
      end else if (fill_done) begin
         state_d           = IDLE;
         mem_rd_d          = 1'b0;
         valid_d[fill_idx] = 1'b1;
         resp_valid_d      = 1'b1;
         resp_hit_d        = 1'b0;
         resp_data_d       = sel_word(bus.mem_line, addr_q[1:0]);
      end else begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         valid_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_hit_q   <= 1'b0;
         resp_data_q  <= '0;
         mem_addr_q   <= '0;
         mem_rd_q     <= 1'b0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         valid_q      <= valid_d;
         resp_valid_q <= resp_valid_d;
         resp_hit_q   <= resp_hit_d;
         resp_data_q  <= resp_data_d;
         mem_addr_q   <= mem_addr_d;
         mem_rd_q     <= mem_rd_d;
         hit_cnt_q    <= hit_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end

   // Line storage has no reset; reset forces IDLE so an interrupted fill never writes.
   always_ff @(posedge clk) begin
      if (fill_done) begin
         tag_mem[fill_idx]  <= fill_tag;
         line_mem[fill_idx] <= bus.mem_line;
      end
   end
endmodule

// File: doc/cache_fill_ctrl.md
CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 5, meaning the number of line-index bits (2^INDEX_BITS direct-mapped lines).
REQ-002 SHALL have parameter MEM_LATENCY, default 2, meaning the cycles mem_addr is held before mem_line is sampled (legal range 1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, an asynchronous active-high reset.
REQ-005 SHALL have port cpu_req, input, 1, meaning a read request is valid.
REQ-006 SHALL have port cpu_addr, input, 15, meaning the word address of the request.
REQ-007 SHALL have port cpu_ready, output, 1, meaning a request is accepted this cycle if cpu_req=1.
REQ-008 SHALL have port resp_valid, output, 1, a one-cycle pulse meaning resp_data is valid.
REQ-009 SHALL have port resp_data, output, 32, the requested word.
REQ-010 SHALL have port resp_hit, output, 1, meaning the response was a hit; valid with resp_valid.
REQ-011 SHALL have port flush, input, 1, meaning all lines are to be invalidated.
REQ-012 SHALL have port mem_addr, output, 15, the block address presented to data memory.
REQ-013 SHALL have port mem_rd, output, 1, high while a fill is in progress.
REQ-014 SHALL have port mem_line, input, 128, the 4-word block returned by data memory.
REQ-015 SHALL have ports hit_cnt and miss_cnt, output, 16 each, the hit and miss statistics counters.

Function
REQ-016 SHALL split cpu_addr into offset=[1:0], index=[INDEX_BITS+1:2], and tag=remaining upper bits.
REQ-017 SHALL store one valid bit, one tag, and one 128-bit line per index.
REQ-018 SHALL map offset 0 to mem_line[127:96], offset 1 to [95:64], offset 2 to [63:32], and offset 3 to [31:0].
REQ-019 SHALL implement states IDLE and FILL; cpu_ready = (state==IDLE) && !flush.
REQ-020 SHALL, on a request accepted in cycle T with a hit (valid and tag equal), assert resp_valid=1, resp_hit=1, and the selected word in cycle T+1, and stay in IDLE (back-to-back hits allowed).
REQ-021 SHALL, on a miss accepted in cycle T, enter FILL for cycles T+1..T+MEM_LATENCY, with mem_addr={cpu_addr[14:2],2'b00} and mem_rd=1 throughout.
REQ-022 SHALL, at the edge ending cycle T+MEM_LATENCY, sample mem_line, write line/tag, set valid, and register the word at the captured offset.
REQ-023 SHALL, in cycle T+MEM_LATENCY+1, assert resp_valid=1 and resp_hit=0, be in IDLE, and have cpu_ready=1.
REQ-024 SHALL hold cpu_req/cpu_addr changes in FILL without effect; the request address is latched at acceptance.
REQ-025 SHALL hold mem_addr at its last value when not filling, with mem_rd=0.
REQ-026 SHALL, on flush=1 in IDLE, clear all valid bits at that edge; flush has priority over a simultaneous cpu_req, which is not accepted.
REQ-027 SHALL take no action on flush during FILL; if flush is still high in the first IDLE cycle, it clears all lines then, including the just-filled one.
REQ-028 SHALL increment hit_cnt per accepted hit and miss_cnt per accepted miss, each saturating at 16'hFFFF.
REQ-029 SHALL hold resp_data at its last value when resp_valid=0.

Reset
REQ-030 SHALL, on rst=1 at any time including mid-FILL, immediately force state=IDLE, all valid bits=0, resp_valid=0, resp_hit=0, resp_data=0, mem_addr=0, mem_rd=0, and hit_cnt=miss_cnt=0.
REQ-031 SHALL discard any fill interrupted by reset, producing no response and writing no line.
REQ-032 SHALL have cpu_ready=1 in the first cycle after rst deasserts (flush=0).

Verification (memory model mem[i]=i, 1-cycle combinational read, MEM_LATENCY=2)
REQ-033 SHALL pass: read 0x0005 after reset -> mem_addr=0x0004, mem_rd high 2 cycles, resp_valid in cycle T+3 with resp_data=5, resp_hit=0, miss_cnt=1.
REQ-034 SHALL pass: then read 0x0006, 0x0007 back-to-back -> responses at T+1 and T+2, data 6 and 7, resp_hit=1, hit_cnt=2.
REQ-035 SHALL pass: read 0x0085 (same index 1, different tag) -> miss, data 0x85; then 0x0005 -> miss again, data 5.
REQ-036 SHALL pass: flush with simultaneous cpu_req in IDLE -> request not accepted; next read 0x0005 -> miss.
REQ-037 SHALL pass: rst pulsed in the first FILL cycle -> no resp_valid, counters 0, and a subsequent read of the same address misses.
REQ-038 SHALL pass: 65536 hits forced -> hit_cnt stays at 0xFFFF.
